// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding and counter sizing shared by the serial subtractor
package serial_sub_pkg;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;
    typedef enum logic [1:0] {IDLE = S_IDLE, RUN = S_RUN, DONE = S_DONE} state_t;
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction
endpackage

// File: rtl/serial_subtract_ctrl_if.sv
// serial_subtract_ctrl_if: start/busy/done handshake plus operands and result
interface serial_subtract_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    modport master (output start, a, b, input busy, done, diff, borrow_out);
    modport slave (input start, a, b, output busy, done, diff, borrow_out);
endinterface

// File: rtl/sub_bit_cell.sv
// sub_bit_cell: 1-bit full subtractor from two half-subtract stages
module sub_bit_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1, b1, b2;
    assign d1   = x ^ y;
    assign b1   = ~x & y;
    assign d    = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl: bit-serial a-b, one bit per clock LSB first, start/busy/done handshake
module serial_subtract_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_subtract_ctrl_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] sa, sb, res;
    logic [CW-1:0]    cnt;
    logic             brw, d, bout;
    sub_bit_cell u_cell (.x(sa[0]), .y(sb[0]), .bin(brw), .d(d), .bout(bout));
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            sa             <= '0;
            sb             <= '0;
            res            <= '0;
            cnt            <= '0;
            brw            <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.diff       <= '0;
            bus.borrow_out <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (bus.start) begin
                        sa       <= bus.a;
                        sb       <= bus.b;
                        res      <= '0;
                        brw      <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= {d, res[WIDTH-1:1]};
                    brw <= bout;
                    cnt <= cnt + CW'(1);
                    // final bit: publish the result so it is valid alongside done
                    if (cnt == CW'(WIDTH - 1)) begin
                        cnt            <= '0;
                        bus.done       <= 1'b1;
                        bus.diff       <= {d, res[WIDTH-1:1]};
                        bus.borrow_out <= bout;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// tb_serial_subtract_ctrl: directed and random checks of 8- and 16-bit serial subtractors
module tb_serial_subtract_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;
    always #5 clk = ~clk;
    serial_subtract_ctrl_if #(.WIDTH(8))  i8 ();
    serial_subtract_ctrl_if #(.WIDTH(16)) i16 ();
    serial_subtract_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
    serial_subtract_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin
            i8.start = s; i8.a = a[7:0]; i8.b = b[7:0];
        end else begin
            i16.start = s; i16.a = a[15:0]; i16.b = b[15:0];
        end
    endtask

    function automatic logic dn(input int w);
        return (w == 8) ? i8.done : i16.done;
    endfunction
    function automatic logic bz(input int w);
        return (w == 8) ? i8.busy : i16.busy;
    endfunction
    function automatic logic bo(input int w);
        return (w == 8) ? i8.borrow_out : i16.borrow_out;
    endfunction
    function automatic logic [31:0] df(input int w);
        return (w == 8) ? 32'(i8.diff) : 32'(i16.diff);
    endfunction

    // one transaction; noisy keeps start high with fresh operands while busy
    task automatic op(input int w, input logic [31:0] a, input logic [31:0] b, input bit noisy);
        logic [63:0] m, am, bm;
        logic [31:0] ed, prev;
        int n, nb;
        m    = (64'd1 << w) - 64'd1;
        am   = 64'(a) & m;
        bm   = 64'(b) & m;
        ed   = 32'((am - bm) & m);
        prev = df(w);
        @(negedge clk);
        drv(w, 1'b1, a, b);
        @(negedge clk);
        drv(w, noisy, $urandom, $urandom);
        n = 1;
        nb = 0;
        forever begin
            nb += int'(bz(w));
            if (dn(w) === 1'b1 || n >= w + 8) break;
            chk("hold_diff", df(w), prev);
            @(negedge clk);
            n++;
            if (noisy) drv(w, 1'b1, $urandom, $urandom);
        end
        chk("latency", 32'(n), 32'(w + 1));
        chk("busy_cycles", 32'(nb), 32'(w + 1));
        chk("diff", df(w), ed);
        chk("borrow_out", 32'(bo(w)), 32'(am < bm));
        @(negedge clk);
        drv(w, 1'b0, $urandom, $urandom);
        chk("done_pulse_end", 32'(dn(w)), 32'd0);
        chk("busy_end", 32'(bz(w)), 32'd0);
        @(negedge clk);
        chk("no_restart", 32'(bz(w)), 32'd0);
    endtask

    initial begin
        int seen;
        drv(8, 1'b0, 0, 0);
        drv(16, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(i8.busy), 32'd0);
        chk("rst_done", 32'(i8.done), 32'd0);
        chk("rst_diff", 32'(i8.diff), 32'd0);
        chk("rst_borrow", 32'(i8.borrow_out), 32'd0);
        chk("rst_diff16", 32'(i16.diff), 32'd0);
        rst_n = 1'b1;
        op(8, 32'h05, 32'h03, 1'b0);
        op(8, 32'h03, 32'h05, 1'b0);
        op(8, 32'h00, 32'hFF, 1'b0);
        op(8, 32'hFF, 32'h01, 1'b0);
        op(8, 32'h00, 32'h00, 1'b0);
        op(8, 32'hA5, 32'hA5, 1'b0);
        op(8, 32'h5A, 32'h00, 1'b0);
        op(8, 32'h3C, 32'hC3, 1'b1);
        for (int i = 0; i < 200; i++) op(8, $urandom, $urandom, 1'b0);
        op(16, 32'h1234, 32'h4321, 1'b0);
        for (int i = 0; i < 10; i++) op(16, $urandom, $urandom, 1'b0);
        op(8, 32'h03, 32'h05, 1'b0);
        // abandon an operation at RUN cycle 4
        @(negedge clk);
        drv(8, 1'b1, 32'h80, 32'h01);
        @(negedge clk);
        drv(8, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(i8.busy), 32'd0);
        chk("midrst_done", 32'(i8.done), 32'd0);
        chk("midrst_diff", 32'(i8.diff), 32'd0);
        chk("midrst_borrow", 32'(i8.borrow_out), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            seen += int'(i8.done);
        end
        chk("midrst_no_done", 32'(seen), 32'd0);
        op(8, 32'h80, 32'h01, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
